universal_reg: RTL and testbench

Parametrised multi-bit storage register, the clocked successor to the enabled SR latch cell.

---
 rtl/universal_reg.sv | 144 ++++++++++++++
 tb/tb_universal_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_reg.sv
// -----------------------------------------------------------------------------
// universal_reg
//
// General-purpose datapath register for the CPU: a clocked set/clear register
// that also loads, shifts, rotates, increments and decrements. The bit moved
// out of the register (or the carry/borrow) is kept in a registered co bit.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset (overrides everything)
//   en     in   1      clock enable; 0 holds q/co, err still clears
//   set    in   1      q <= all ones
//   clr    in   1      q <= 0 (set & clr together is flagged on err)
//   mode   in   3      operation select, see mode_e below
//   d      in   WIDTH  parallel load data
//   sin_l  in   1      serial input entering at the MSB on SHR
//   sin_r  in   1      serial input entering at the LSB on SHL
//   q      out  WIDTH  register contents
//   co     out  1      registered carry / borrow / shifted-out bit
//   zero   out  1      combinational, q == 0
//   err    out  1      one-cycle pulse after set & clr were asserted with en
//
// Build option:
//   UREG_ARITH_SHR_EN  when defined, SHR is arithmetic (MSB replicated and
//                      sin_l ignored); otherwise SHR fills the MSB from sin_l.
// -----------------------------------------------------------------------------
module universal_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             set,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             zero,
  output logic             err
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] data_q, data_d;
  logic             co_q, co_d;
  logic             err_q, err_d;
  logic             shr_fill;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

`ifdef UREG_ARITH_SHR_EN
  assign shr_fill = data_q[WIDTH-1];
`else
  assign shr_fill = sin_l;
`endif

  // Next-state logic. Priority: en=0 > set/clr > mode.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    data_d = data_q;
    co_d   = co_q;
    err_d  = 1'b0;
    if (en) begin
      if (set && clr) begin
        // Forbidden SR combination: contents and co are preserved.
        err_d = 1'b1;
      end else if (set) begin
        data_d = '1;
        co_d   = 1'b0;
      end else if (clr) begin
        data_d = '0;
        co_d   = 1'b0;
      end else begin
        case (mode_s)
          MODE_HOLD: ;
          MODE_LOAD: begin
            data_d = d;
            co_d   = 1'b0;
          end
          MODE_SHL: begin
            data_d = {data_q[WIDTH-2:0], sin_r};
            co_d   = data_q[WIDTH-1];
          end
          MODE_SHR: begin
            data_d = {shr_fill, data_q[WIDTH-1:1]};
            co_d   = data_q[0];
          end
          MODE_ROTL: begin
            data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            co_d   = data_q[WIDTH-1];
          end
          MODE_ROTR: begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
            co_d   = data_q[0];
          end
          MODE_INC: begin
            // WIDTH+1-bit sum: the extra bit is the carry out of all-ones.
            {co_d, data_d} = {1'b0, data_q} + (WIDTH+1)'(1);
          end
          MODE_DEC: begin
            data_d = data_q - WIDTH'(1);
            co_d   = (data_q == '0);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      data_q <= RESET_VAL;
      co_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      co_q   <= co_d;
      err_q  <= err_d;
    end
  end

  assign q    = data_q;
  assign co   = co_q;
  assign err  = err_q;
  assign zero = (data_q == '0);

endmodule

// File: tb/tb_universal_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_reg
//
// Directed bench for universal_reg (WIDTH=8, RESET_VAL=8'h5A). An arithmetic
// reference model tracks the expected register value; a compare process checks
// every output against it on each falling edge once reset has been applied.
// Hand-computed literal checks pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_universal_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;

  localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_SHL = 3'd2,
                         M_SHR  = 3'd3, M_ROTL = 3'd4, M_ROTR = 3'd5,
                         M_INC  = 3'd6, M_DEC  = 3'd7;

  logic         clk = 1'b0;
  logic         rst, en, set, clr, sin_l, sin_r;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         co, zero, err;

  int n_checks = 0;
  int n_errors = 0;

  universal_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .set(set), .clr(clr), .mode(mode),
    .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .q(q), .co(co), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ---------------
  logic [7:0] m_q;
  logic       m_co, m_err;
  logic       m_valid = 1'b0;

  // Returns {co, q} after one mode operation on value qv.
  function automatic logic [8:0] model_op(input int qv, input logic cv,
                                          input logic [2:0] m, input int dv,
                                          input int sl, input int sr);
    int nq, nc;
    nq = qv;
    nc = int'(cv);
    case (m)
      M_HOLD: ;
      M_LOAD: begin nq = dv; nc = 0; end
      M_SHL:  begin nq = (qv * 2 + sr) % 256; nc = qv / 128; end
`ifdef UREG_ARITH_SHR_EN
      M_SHR:  begin nq = qv / 2 + (qv / 128) * 128; nc = qv % 2; end
`else
      M_SHR:  begin nq = qv / 2 + sl * 128; nc = qv % 2; end
`endif
      M_ROTL: begin nq = (qv * 2) % 256 + qv / 128; nc = qv / 128; end
      M_ROTR: begin nq = qv / 2 + (qv % 2) * 128; nc = qv % 2; end
      M_INC:  begin nq = (qv + 1) % 256; nc = (qv == 255) ? 1 : 0; end
      M_DEC:  begin nq = (qv + 255) % 256; nc = (qv == 0) ? 1 : 0; end
      default: ;
    endcase
    return 9'(nc * 256 + nq);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q     <= RV;
      m_co    <= 1'b0;
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else if (!en) begin
      m_err <= 1'b0;
    end else if (set && clr) begin
      m_err <= 1'b1;
    end else if (set) begin
      m_q <= 8'hFF; m_co <= 1'b0; m_err <= 1'b0;
    end else if (clr) begin
      m_q <= 8'h00; m_co <= 1'b0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      {m_co, m_q} <= model_op(int'(m_q), m_co, mode, int'(d),
                              int'(sin_l), int'(sin_r));
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("q",    int'(q),    int'(m_q));
      check("co",   int'(co),   int'(m_co));
      check("err",  int'(err),  int'(m_err));
      check("zero", int'(zero), (m_q == 8'h00) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs for one rising edge, return after the following falling edge.
  task automatic step(input logic e, input logic s, input logic c,
                      input logic [2:0] m, input logic [7:0] dv,
                      input logic sl, input logic sr);
    en = e; set = s; clr = c; mode = m; d = dv; sin_l = sl; sin_r = sr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] dv);
    step(1'b1, 1'b0, 1'b0, m, dv, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; set = 1'b0; clr = 1'b0; mode = M_HOLD;
    d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    @(negedge clk);

    // Reset for one edge.
    step(1'b0, 1'b0, 1'b0, M_HOLD, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    check("reset_q",    int'(q), 'h5A);
    check("reset_co",   int'(co), 0);
    check("reset_err",  int'(err), 0);
    check("reset_zero", int'(zero), 0);

    // Enable low: LOAD FF has no effect for three edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0);
    check("en0_hold_q", int'(q), 'h5A);

    // Load 00 then count up through the wrap.
    op(M_LOAD, 8'h00);
    check("load0_q", int'(q), 0);
    check("load0_zero", int'(zero), 1);
    for (int i = 1; i <= 256; i++) begin
      op(M_INC, 8'h00);
      if (i == 255) begin
        check("inc255_q", int'(q), 'hFF);
        check("inc255_co", int'(co), 0);
      end
      if (i == 256) begin
        check("inc256_q", int'(q), 0);
        check("inc256_co", int'(co), 1);
      end
    end
    // co holds while disabled, even with set/clr asserted.
    step(1'b0, 1'b1, 1'b1, M_DEC, 8'h00, 1'b0, 1'b0);
    check("en0_co_hold", int'(co), 1);
    check("en0_no_err", int'(err), 0);

    // Decrement through zero.
    op(M_LOAD, 8'h00);
    op(M_DEC, 8'h00);
    check("dec_wrap_q", int'(q), 'hFF);
    check("dec_wrap_co", int'(co), 1);
    op(M_DEC, 8'h00);
    check("dec_q", int'(q), 'hFE);
    check("dec_co", int'(co), 0);

    // Shifts and rotates on 81.
    op(M_LOAD, 8'h81);
    step(1'b1, 1'b0, 1'b0, M_SHL, 8'h00, 1'b0, 1'b1);
    check("shl_q", int'(q), 'h03);
    check("shl_co", int'(co), 1);
    op(M_ROTR, 8'h00);
    check("rotr_q", int'(q), 'h81);
    check("rotr_co", int'(co), 1);
    op(M_SHR, 8'h00);
`ifdef UREG_ARITH_SHR_EN
    check("shr_q", int'(q), 'hC0);
`else
    check("shr_q", int'(q), 'h40);
`endif
    check("shr_co", int'(co), 1);
    op(M_ROTL, 8'h00);
    step(1'b1, 1'b0, 1'b0, M_SHR, 8'h00, 1'b1, 1'b0);
    op(M_HOLD, 8'h00);

    // Set, clear, forbidden combination.
    step(1'b1, 1'b1, 1'b0, M_INC, 8'h00, 1'b0, 1'b0);
    check("set_q", int'(q), 'hFF);
    check("set_co", int'(co), 0);
    step(1'b1, 1'b0, 1'b1, M_INC, 8'h00, 1'b0, 1'b0);
    check("clr_q", int'(q), 0);
    op(M_LOAD, 8'h3C);
    step(1'b1, 1'b1, 1'b1, M_LOAD, 8'h00, 1'b0, 1'b0);
    check("forbid_q", int'(q), 'h3C);
    check("forbid_err", int'(err), 1);
    op(M_HOLD, 8'h00);
    check("forbid_err_clr", int'(err), 0);
    check("forbid_q_after", int'(q), 'h3C);

    // Reset in the middle of a counting run.
    op(M_LOAD, 8'h00);
    for (int i = 0; i < 7; i++) op(M_INC, 8'h00);
    check("run_q", int'(q), 'h07);
    rst = 1'b1;
    op(M_INC, 8'h00);
    rst = 1'b0;
    check("midrst_q", int'(q), 'h5A);
    check("midrst_co", int'(co), 0);
    op(M_INC, 8'h00);
    check("resume_q", int'(q), 'h5B);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
